// File: rtl/audio_mix_sequencer.sv
// audio_mix_sequencer: per-frame 2x2 Q2.14 mixing matrix on one shared multiplier,
// with shadow coefficients swapped in atomically at frame start.
module audio_mix_sequencer #(
  parameter logic [7:0] START_CNT = 8'd2,
  parameter int         FRAC_BITS = 14
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [7:0]  cnt256_n,
  input  logic [15:0] ch1_in,
  input  logic [15:0] ch2_in,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        cfg_pending,
  output logic        busy,
  output logic        out_valid,
  output logic [15:0] ch1_out,
  output logic [15:0] ch2_out
);
  typedef enum logic [2:0] {IDLE, P11, P12, P21, P22, WR2} state_t;
  state_t             state_q;
  logic signed [15:0] x1_q, x2_q, mul_a, mul_b;
  logic signed [15:0] act_q [4];
  logic signed [15:0] shd_q [4];
  logic signed [31:0] prod;
  logic signed [32:0] acc_q, prod_x, acc_sh;
  logic [15:0]        sat_d;
  always_comb begin
    mul_a  = (state_q == P11 || state_q == P21) ? x1_q : x2_q;
    mul_b  = act_q[state_q == P11 ? 2'd0 : state_q == P12 ? 2'd1 : state_q == P21 ? 2'd2 : 2'd3];
    prod   = mul_a * mul_b;
    prod_x = {prod[31], prod};
    acc_sh = acc_q >>> FRAC_BITS;
    sat_d  = acc_sh > 33'sd32767 ? 16'h7fff : acc_sh < -33'sd32768 ? 16'h8000 : acc_sh[15:0];
  end
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      cfg_pending <= 1'b0;
      ch1_out     <= '0;
      ch2_out     <= '0;
      acc_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      act_q       <= '{16'sh4000, 16'sh0, 16'sh0, 16'sh4000};
      shd_q       <= '{16'sh4000, 16'sh0, 16'sh0, 16'sh4000};
    end else begin
      out_valid <= 1'b0;
      if (cfg_we) shd_q[cfg_addr] <= cfg_wdata;
      if (cfg_commit) cfg_pending <= 1'b1;
      case (state_q)
        IDLE: if (cnt256_n == START_CNT) begin
          x1_q    <= ch1_in;
          x2_q    <= ch2_in;
          busy    <= 1'b1;
          state_q <= P11;
          // swap uses pre-edge shadow; a same-edge commit re-arms the next frame
          if (cfg_pending) begin
            act_q       <= shd_q;
            cfg_pending <= cfg_commit;
          end
        end
        P11: begin
          acc_q   <= prod_x;
          state_q <= P12;
        end
        P12: begin
          acc_q   <= acc_q + prod_x;
          state_q <= P21;
        end
        P21: begin
          ch1_out <= sat_d;
          acc_q   <= prod_x;
          state_q <= P22;
        end
        P22: begin
          acc_q   <= acc_q + prod_x;
          state_q <= WR2;
        end
        WR2: begin
          ch2_out   <= sat_d;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_mix_sequencer.sv
// tb_audio_mix_sequencer: directed frames; expected outputs queued by the stimulus
// and checked by a monitor on each out_valid pulse.
module tb_audio_mix_sequencer;
  logic        mclk = 1'b0;
  logic        rst_n;
  logic [7:0]  cnt256_n;
  logic [15:0] ch1_in, ch2_in, cfg_wdata, ch1_out, ch2_out;
  logic        cfg_we, cfg_commit, cfg_pending, busy, out_valid;
  logic [1:0]  cfg_addr;
  logic [31:0] exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  audio_mix_sequencer dut (
    .mclk(mclk), .rst_n(rst_n), .cnt256_n(cnt256_n), .ch1_in(ch1_in), .ch2_in(ch2_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .busy(busy), .out_valid(out_valid),
    .ch1_out(ch1_out), .ch2_out(ch2_out)
  );
  always #5 mclk = ~mclk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge mclk) begin
    #1;
    if (out_valid === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid: got ch1=%h ch2=%h expected no pulse", ch1_out, ch2_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({ch1_out, ch2_out} !== e) begin
          n_fail++;
          $display("FAIL mix_out: got %h_%h expected %h_%h", ch1_out, ch2_out, e[31:16], e[15:0]);
        end
      end
    end
  end
  task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
    @(posedge mclk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge mclk); #1;
    cfg_we = 1'b0;
  endtask
  task automatic commit();
    @(posedge mclk); #1;
    cfg_commit = 1'b1;
    @(posedge mclk); #1;
    cfg_commit = 1'b0;
    chk("pending_set", 16'(cfg_pending), 16'h1);
  endtask
  // cnt256_n is held at START_CNT through E1 too, which the running FSM must ignore
  task automatic run_frame(input logic [15:0] x1, x2, e1, e2, input logic ep, input logic hook);
    @(posedge mclk); #1;
    ch1_in = x1; ch2_in = x2; cnt256_n = 8'd2;
    exp_q.push_back({e1, e2});
    if (hook) begin
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'h1000; cfg_commit = 1'b1;
    end
    @(posedge mclk); #1;
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("busy_e0", 16'(busy), 16'h1);
    chk("pending_e0", 16'(cfg_pending), 16'(ep));
    for (int k = 1; k <= 5; k++) begin
      @(posedge mclk); #1;
      cnt256_n = 8'(k + 2);
      chk($sformatf("busy_e%0d", k), 16'(busy), k < 5 ? 16'h1 : 16'h0);
      chk($sformatf("valid_e%0d", k), 16'(out_valid), k == 5 ? 16'h1 : 16'h0);
      if (k == 3) chk("ch1_e3", ch1_out, e1);
    end
    cnt256_n = 8'd0;
    @(posedge mclk); #1;
    chk("valid_after", 16'(out_valid), 16'h0);
    chk("ch2_hold", ch2_out, e2);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; cnt256_n = 8'd0; ch1_in = '0; ch2_in = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_pending", 16'(cfg_pending), 16'h0);
    chk("rst_ch1", ch1_out, 16'h0);
    chk("rst_ch2", ch2_out, 16'h0);
    rst_n = 1'b1;
    run_frame(16'h1234, 16'hF000, 16'h1234, 16'hF000, 1'b0, 1'b0);
    cfg_wr(2'd0, 16'h0000); cfg_wr(2'd1, 16'h4000); cfg_wr(2'd2, 16'h4000); cfg_wr(2'd3, 16'h0000);
    chk("no_commit_pending", 16'(cfg_pending), 16'h0);
    run_frame(16'h1234, 16'hF000, 16'h1234, 16'hF000, 1'b0, 1'b0);
    commit();
    run_frame(16'h1234, 16'hF000, 16'hF000, 16'h1234, 1'b0, 1'b0);
    cfg_wr(2'd0, 16'h4000);
    commit();
    run_frame(16'h7000, 16'h7000, 16'h7FFF, 16'h7000, 1'b0, 1'b0);
    run_frame(16'h9000, 16'h9000, 16'h8000, 16'h9000, 1'b0, 1'b0);
    cfg_wr(2'd0, 16'h2000); cfg_wr(2'd1, 16'h0000);
    commit();
    run_frame(16'hFFFD, 16'h1111, 16'hFFFE, 16'hFFFD, 1'b0, 1'b0);
    run_frame(16'h0003, 16'h1111, 16'h0001, 16'h0003, 1'b0, 1'b0);
    cfg_wr(2'd0, 16'h4000);
    commit();
    run_frame(16'h0800, 16'h0100, 16'h0800, 16'h0800, 1'b1, 1'b1);
    run_frame(16'h0800, 16'h0100, 16'h0200, 16'h0800, 1'b0, 1'b0);
    @(posedge mclk); #1;
    ch1_in = 16'h0800; ch2_in = 16'h0100; cnt256_n = 8'd2;
    @(posedge mclk); #1;
    cnt256_n = 8'd3;
    repeat (2) @(posedge mclk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ch1", ch1_out, 16'h0);
    chk("abort_ch2", ch2_out, 16'h0);
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_valid", 16'(out_valid), 16'h0);
    cnt256_n = 8'd0;
    repeat (3) @(posedge mclk);
    #1;
    rst_n = 1'b1;
    chk("abort_no_valid", 16'(out_valid), 16'h0);
    run_frame(16'h1234, 16'hF000, 16'h1234, 16'hF000, 1'b0, 1'b0);
    commit();
    run_frame(16'h0100, 16'h0200, 16'h0100, 16'h0200, 1'b0, 1'b0);
    repeat (3) @(posedge mclk);
    #1;
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
